// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot pipeline: screen geometry, RGB332
// palette, writer FSM states and the per-pixel result record.
package mandel_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int MAX_ITER = 1000;

    localparam logic [7:0] COL_BLACK  = 8'h00;
    localparam logic [7:0] COL_RED    = 8'hE0;
    localparam logic [7:0] COL_ORANGE = 8'hEC;
    localparam logic [7:0] COL_YELLOW = 8'hFC;
    localparam logic [7:0] COL_GREEN  = 8'h1C;
    localparam logic [7:0] COL_CYAN   = 8'h1F;
    localparam logic [7:0] COL_BLUE   = 8'h03;
    localparam logic [7:0] COL_DARK   = 8'h01;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE} wr_state_t;

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [10:0] count;
    } pixel_result;

    // Bands halve towards zero, so slow-escaping points get the warm colours.
    function automatic logic [7:0] rgb332_of(input logic [10:0] c, input int max_iter);
        logic [31:0] cu;
        logic [31:0] m;
        cu = 32'(c);
        m  = 32'(max_iter);
        if (cu >= m)              return COL_BLACK;
        else if (cu >= (m >> 1))  return COL_RED;
        else if (cu >= (m >> 2))  return COL_ORANGE;
        else if (cu >= (m >> 3))  return COL_YELLOW;
        else if (cu >= (m >> 4))  return COL_GREEN;
        else if (cu >= (m >> 5))  return COL_CYAN;
        else if (cu >= (m >> 6))  return COL_BLUE;
        else                      return COL_DARK;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with full/empty flags and show-ahead read data.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pixel_color_writer.sv
// Takes finished Mandelbrot pixels, colours them and writes them to the VGA
// framebuffer with a held write request; tracks frame progress.
module pixel_color_writer #(
    parameter int MAX_ITER   = mandel_pkg::MAX_ITER,
    parameter int SCREEN_W   = mandel_pkg::SCREEN_W,
    parameter int SCREEN_H   = mandel_pkg::SCREEN_H,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9:0]        in_x,
    input  logic [8:0]        in_y,
    input  logic [10:0]       in_count,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    output logic              fb_we,
    input  logic              fb_ack,
    input  logic              clear_frame,
    output logic              frame_done,
    output logic [ADDR_W-1:0] pixels_written,
    output logic              coord_err
);

    import mandel_pkg::*;

    localparam int                ENTRY_W = $bits(pixel_result);
    localparam logic [31:0]       W_U     = 32'(SCREEN_W);
    localparam logic [31:0]       H_U     = 32'(SCREEN_H);
    localparam logic [ADDR_W-1:0] TOTAL   = ADDR_W'(SCREEN_W * SCREEN_H);

    logic        ready_q;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        in_range;
    logic        accept;
    pixel_result wr_entry;
    pixel_result rd_entry;
    pixel_result cur;
    wr_state_t   state;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [9:0] x, input logic [8:0] y);
        logic [ADDR_W-1:0] xa;
        logic [ADDR_W-1:0] ya;
        xa = ADDR_W'(x);
        ya = ADDR_W'(y);
        if (SCREEN_W == 640) return (ya << 9) + (ya << 7) + xa;
        else                 return ya * ADDR_W'(SCREEN_W) + xa;
    endfunction

    // in_ready stays low until the first clock after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    assign in_ready = ready_q & ~full;
    assign accept   = in_valid & in_ready;
    assign in_range = (32'(in_x) < W_U) && (32'(in_y) < H_U);
    assign push     = accept & in_range;
    assign wr_entry = '{x: in_x, y: in_y, count: in_count};
    // Pops line up exactly with the FSM capturing rd_entry into cur.
    assign pop      = ~empty & ((state == IDLE) | ((state == WRITE) & fb_ack));

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cur     <= '0;
            fb_addr <= '0;
            fb_data <= '0;
            fb_we   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        cur   <= rd_entry;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    fb_addr <= addr_of(cur.x, cur.y);
                    fb_data <= rgb332_of(cur.count, MAX_ITER);
                    fb_we   <= 1'b1;
                    state   <= WRITE;
                end
                WRITE: begin
                    if (fb_ack) begin
                        fb_we <= 1'b0;
                        if (!empty) begin
                            cur   <= rd_entry;
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A clear on the ack cycle wins, so that write is not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixels_written <= '0;
            frame_done     <= 1'b0;
        end else if (clear_frame) begin
            pixels_written <= '0;
            frame_done     <= 1'b0;
        end else if ((state == WRITE) && fb_ack && (pixels_written != TOTAL)) begin
            pixels_written <= pixels_written + ADDR_W'(1);
            if (pixels_written + ADDR_W'(1) == TOTAL) frame_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  coord_err <= 1'b0;
        else if (accept && !in_range) coord_err <= 1'b1;
    end

endmodule
